// File: rtl/gba_keypad_pkg.sv
// Shared constants and helpers for the GBA keypad front end: key bit
// positions in both layouts, KEYCNT fields, the SNES->GBA remap and the
// KEYCNT condition evaluation.
package gba_keypad_pkg;

    // GBA KEYINPUT bit positions
    localparam int GBA_KEY_A      = 0;
    localparam int GBA_KEY_B      = 1;
    localparam int GBA_KEY_SELECT = 2;
    localparam int GBA_KEY_START  = 3;
    localparam int GBA_KEY_RIGHT  = 4;
    localparam int GBA_KEY_LEFT   = 5;
    localparam int GBA_KEY_UP     = 6;
    localparam int GBA_KEY_DOWN   = 7;
    localparam int GBA_KEY_R      = 8;
    localparam int GBA_KEY_L      = 9;

    // SNES controller shift-word bit positions
    localparam int SNES_B      = 0;
    localparam int SNES_SELECT = 2;
    localparam int SNES_START  = 3;
    localparam int SNES_UP     = 4;
    localparam int SNES_DOWN   = 5;
    localparam int SNES_LEFT   = 6;
    localparam int SNES_RIGHT  = 7;
    localparam int SNES_A      = 8;
    localparam int SNES_L      = 10;
    localparam int SNES_R      = 11;

    // KEYCNT fields
    localparam int KEYCNT_IRQ_EN = 14;
    localparam int KEYCNT_COND   = 15;

    localparam int NUM_KEYS = 10;

    // Reorder the synchronized SNES word into GBA key order; X, Y and the
    // unused upper bits are dropped here.
    function automatic logic [9:0] snes_to_gba(input logic [15:0] snes);
        logic [9:0] gba;
        gba[GBA_KEY_A]      = snes[SNES_A];
        gba[GBA_KEY_B]      = snes[SNES_B];
        gba[GBA_KEY_SELECT] = snes[SNES_SELECT];
        gba[GBA_KEY_START]  = snes[SNES_START];
        gba[GBA_KEY_RIGHT]  = snes[SNES_RIGHT];
        gba[GBA_KEY_LEFT]   = snes[SNES_LEFT];
        gba[GBA_KEY_UP]     = snes[SNES_UP];
        gba[GBA_KEY_DOWN]   = snes[SNES_DOWN];
        gba[GBA_KEY_R]      = snes[SNES_R];
        gba[GBA_KEY_L]      = snes[SNES_L];
        return gba;
    endfunction

    // Gated interrupt condition from the active-low key state and KEYCNT.
    // An empty select mask never produces a true condition.
    function automatic logic keypad_gate(input logic [9:0]  keys_n,
                                         input logic [15:0] cnt);
        logic [9:0] mask;
        logic [9:0] pressed;
        logic       cond;
        mask    = cnt[9:0];
        pressed = ~keys_n & mask;
        if (cnt[KEYCNT_COND]) begin
            cond = (pressed == mask) && (mask != 10'd0);
        end else begin
            cond = |pressed;
        end
        return cond & cnt[KEYCNT_IRQ_EN];
    endfunction

endpackage

// File: rtl/gba_keypad_ctrl_key_debounce.sv
// One-key debouncer: accepts a new level only after STABLE_SAMPLES
// consecutive ticks that disagree with the current stable state.
module key_debounce #(
    parameter int STABLE_SAMPLES = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic sample,
    output logic stable
);

    localparam logic [2:0] LAST_CNT = 3'(STABLE_SAMPLES - 1);

    logic       stable_r;
    logic [2:0] agree_r;

    // Stable level and disagreement counter, advanced only on sample ticks
    always_ff @(posedge clock) begin
        if (reset) begin
            stable_r <= 1'b1;
            agree_r  <= 3'd0;
        end else if (tick) begin
            if (sample == stable_r) begin
                agree_r <= 3'd0;
            end else if (agree_r == LAST_CNT) begin
                stable_r <= sample;
                agree_r  <= 3'd0;
            end else begin
                agree_r <= agree_r + 3'd1;
            end
        end else begin
            agree_r <= agree_r;
        end
    end

    assign stable = stable_r;

endmodule

// File: rtl/gba_keypad_ctrl.sv
// GBA keypad front end: synchronizes the SNES pad word, debounces each key,
// presents KEYINPUT and raises a single-cycle keypad interrupt from KEYCNT.
module gba_keypad_ctrl
    import gba_keypad_pkg::*;
#(
    parameter int SAMPLE_DIV     = 16384,
    parameter int STABLE_SAMPLES = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] buttons_raw,
    input  logic [15:0] keycnt,
    output logic [15:0] keyinput,
    output logic        keypad_irq
);

    localparam int              DIV_W   = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SAMPLE_DIV - 1);

    logic [15:0]      sync1_r;
    logic [15:0]      sync2_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic             tick_s;
    logic [9:0]       sample_s;
    logic [9:0]       stable_s;
    logic [15:0]      keyinput_r;
    logic             gate_s;
    logic             gate_q_r;
    logic             irq_r;

    // Two-flop synchronizer for the asynchronous pad word (idle = released)
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= 16'hFFFF;
            sync2_r <= 16'hFFFF;
        end else begin
            sync1_r <= buttons_raw;
            sync2_r <= sync1_r;
        end
    end

    // Sample prescaler; tick marks the wrap cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt_r <= '0;
        end else if (div_cnt_r == DIV_MAX) begin
            div_cnt_r <= '0;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    assign tick_s   = (div_cnt_r == DIV_MAX);
    assign sample_s = snes_to_gba(sync2_r);

    genvar k;
    generate
        for (k = 0; k < NUM_KEYS; k++) begin : g_key
            key_debounce #(
                .STABLE_SAMPLES(STABLE_SAMPLES)
            ) u_key_debounce (
                .clock (clock),
                .reset (reset),
                .tick  (tick_s),
                .sample(sample_s[k]),
                .stable(stable_s[k])
            );
        end
    endgenerate

    // Condition is evaluated on the published KEYINPUT so the IRQ trails it
    assign gate_s = keypad_gate(keyinput_r[9:0], keycnt);

    // KEYINPUT register, gate history and rising-edge interrupt pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            keyinput_r <= 16'h03FF;
            gate_q_r   <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            keyinput_r <= {6'b000000, stable_s};
            gate_q_r   <= gate_s;
            irq_r      <= gate_s & ~gate_q_r;
        end
    end

    assign keyinput   = keyinput_r;
    assign keypad_irq = irq_r;

endmodule

// File: tb/tb_gba_keypad_ctrl.sv
// Directed bench for gba_keypad_ctrl with SAMPLE_DIV=4, STABLE_SAMPLES=3.
module tb_gba_keypad_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] buttons_raw;
    logic [15:0] keycnt;
    logic [15:0] keyinput;
    logic        keypad_irq;

    int n_checks = 0;
    int n_fail   = 0;
    int irq_total = 0;
    int irq_snap  = 0;

    gba_keypad_ctrl #(
        .SAMPLE_DIV    (4),
        .STABLE_SAMPLES(3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .buttons_raw(buttons_raw),
        .keycnt     (keycnt),
        .keyinput   (keyinput),
        .keypad_irq (keypad_irq)
    );

    always #5 clock = ~clock;

    // Running count of interrupt pulses, sampled away from the active edge
    always @(negedge clock) begin
        if (keypad_irq === 1'b1) irq_total <= irq_total + 1;
    end

    task automatic wait_key(input logic [15:0] exp, input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clock);
            if (keyinput === exp) break;
        end
        n_checks++;
        assert (keyinput === exp) else begin
            n_fail++;
            $error("FAIL %s: keyinput=%h expected %h", tag, keyinput, exp);
        end
    endtask

    task automatic check_irq(input logic exp, input string tag);
        n_checks++;
        assert (keypad_irq === exp) else begin
            n_fail++;
            $error("FAIL %s: keypad_irq=%b expected %b", tag, keypad_irq, exp);
        end
    endtask

    task automatic check_pulses(input int exp, input string tag);
        repeat (4) @(negedge clock);
        n_checks++;
        assert ((irq_total - irq_snap) === exp) else begin
            n_fail++;
            $error("FAIL %s: pulses=%0d expected %0d", tag, irq_total - irq_snap, exp);
        end
    endtask

    initial begin
        logic glitch_ok;
        reset       = 1'b1;
        buttons_raw = 16'h0000;
        keycnt      = 16'h0000;

        // Reset state with every key pressed on the raw input
        repeat (3) @(negedge clock);
        n_checks++;
        assert (keyinput === 16'h03FF) else begin
            n_fail++;
            $error("FAIL reset_keyinput: keyinput=%h expected %h", keyinput, 16'h03FF);
        end
        check_irq(1'b0, "reset_irq");
        reset = 1'b0;
        wait_key(16'h0000, 15, "reset_release_all_pressed");

        // Remap
        buttons_raw = 16'hFFFF;
        wait_key(16'h03FF, 20, "release_all");
        buttons_raw = 16'hFEFF;
        wait_key(16'h03FE, 20, "remap_A");
        buttons_raw = 16'hFFFF;
        wait_key(16'h03FF, 20, "release_A");
        buttons_raw = 16'hFBFF;
        wait_key(16'h01FF, 20, "remap_L");
        buttons_raw = 16'hFFFF;
        wait_key(16'h03FF, 20, "release_L");

        // Glitch on Start: 6 cycles is at most two samples
        glitch_ok   = 1'b1;
        buttons_raw = 16'hFFF7;
        repeat (6) begin
            @(negedge clock);
            if (keyinput !== 16'h03FF) glitch_ok = 1'b0;
        end
        buttons_raw = 16'hFFFF;
        repeat (20) begin
            @(negedge clock);
            if (keyinput !== 16'h03FF) glitch_ok = 1'b0;
        end
        n_checks++;
        assert (glitch_ok === 1'b1) else begin
            n_fail++;
            $error("FAIL glitch_start: keyinput=%h expected %h", keyinput, 16'h03FF);
        end

        // OR mode over A|B
        keycnt   = 16'h4003;
        irq_snap = irq_total;
        buttons_raw = 16'hFFFE;
        wait_key(16'h03FD, 20, "or_press_B");
        check_pulses(1, "or_B_pulse");
        irq_snap = irq_total;
        buttons_raw = 16'hFEFE;
        wait_key(16'h03FC, 20, "or_press_A_too");
        check_pulses(0, "or_hold_no_repeat");
        irq_snap = irq_total;
        buttons_raw = 16'hFFFF;
        wait_key(16'h03FF, 20, "or_release");
        check_pulses(0, "or_release_no_pulse");
        irq_snap = irq_total;
        buttons_raw = 16'hFEFF;
        wait_key(16'h03FE, 20, "or_press_A");
        check_pulses(1, "or_A_pulse");
        buttons_raw = 16'hFFFF;
        wait_key(16'h03FF, 20, "or_release2");

        // AND mode over Select&Start
        keycnt   = 16'hC00C;
        irq_snap = irq_total;
        buttons_raw = 16'hFFF7;
        wait_key(16'h03F7, 20, "and_press_start");
        check_pulses(0, "and_partial_no_pulse");
        irq_snap = irq_total;
        buttons_raw = 16'hFFF3;
        wait_key(16'h03F3, 20, "and_add_select");
        check_pulses(1, "and_complete_pulse");
        buttons_raw = 16'hFFFF;
        wait_key(16'h03FF, 20, "and_release");
        irq_snap = irq_total;
        buttons_raw = 16'hFFF3;
        wait_key(16'h03F3, 20, "and_two_keys_same_tick");
        check_pulses(1, "and_two_keys_one_pulse");

        // Empty mask in AND mode with everything pressed
        irq_snap = irq_total;
        keycnt   = 16'hC000;
        buttons_raw = 16'hF000;
        wait_key(16'h0000, 20, "and_empty_all_pressed");
        check_pulses(0, "and_empty_mask_no_pulse");

        // Enable while Right held
        buttons_raw = 16'hFF7F;
        keycnt      = 16'h0010;
        irq_snap    = irq_total;
        wait_key(16'h03EF, 20, "hold_right");
        check_pulses(0, "disabled_no_pulse");
        keycnt = 16'h4010;
        @(negedge clock);
        check_irq(1'b1, "enable_pulse");
        @(negedge clock);
        check_irq(1'b0, "enable_single_cycle");
        keycnt = 16'h0010;
        @(negedge clock);
        check_irq(1'b0, "disable_no_pulse");
        keycnt = 16'h4010;
        @(negedge clock);
        check_irq(1'b1, "reenable_pulse");
        @(negedge clock);
        check_irq(1'b0, "reenable_single_cycle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gba_keypad_ctrl.md
# gba_keypad_ctrl

Keypad front end between the SNES `controller` and the interrupt controller: synchronizes and debounces the raw 16-bit pad word, remaps it to the GBA KEYINPUT layout, and evaluates KEYCNT to raise the keypad interrupt. Its outputs are the KEYINPUT value read back through `mem_top` and the `keypad` input of `interrupt_controller`, which is tied off today.

## Interface
- `SAMPLE_DIV`, 16384: `clock` cycles between debounce samples; about 1 ms at 16.776 MHz; minimum 2.
- `STABLE_SAMPLES`, 3: consecutive equal samples needed to accept a key change; range 1..7.
- `clock` in 1: gba_clk.
- `reset` in 1: synchronous, active-high.
- `buttons_raw` in 16: controller shift word, asynchronous to `clock`, active-low.
  - Bit order: 0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right, 8 A, 9 X, 10 L, 11 R; bits 15:12 unused.
- `keycnt` in 16: KEYCNT register.
  - [9:0] key select mask.
  - [14] IRQ enable.
  - [15] condition: 0 = OR, 1 = AND.
- `keyinput` out 16: KEYINPUT, active-low.
  - [9:0] A, B, Select, Start, Right, Left, Up, Down, R, L.
  - [15:10] always 0.
- `keypad_irq` out 1: single-cycle interrupt request pulse.

## Operation
- **Synchronizer:** two-flop synchronizer on all 16 `buttons_raw` bits; bits 15:12 are then discarded.
- **Remap** (GBA bit <- SNES bit): 0<-8, 1<-0, 2<-2, 3<-3, 4<-7, 5<-6, 6<-4, 7<-5, 8<-11, 9<-10. SNES X and Y are ignored.
- **Prescaler:** counts 0..SAMPLE_DIV-1 and wraps; `tick` is asserted on the wrap cycle.
- **Per-key debouncer:**
  - Holds a stable state `s` (reset 1 = released) and a 3-bit agreement counter `c` (reset 0).
  - On `tick`, if sample == `s`: `c` <= 0.
  - On `tick`, if sample != `s` and `c` == STABLE_SAMPLES-1: `s` <= sample, `c` <= 0.
  - On `tick`, otherwise: `c` <= `c`+1.
  - Without `tick`, state holds.
- **keyinput:** `{6'b0, s[9:0]}`, registered.
- **Condition:**
  - `pressed = ~s & keycnt[9:0]`.
  - OR mode: `cond = |pressed`.
  - AND mode: `cond = (pressed == keycnt[9:0]) && (keycnt[9:0] != 0)`.
  - An empty mask never triggers in either mode.
- **Gating:** `g = cond & keycnt[14]`, registered as `g_q`.
- **IRQ:** `keypad_irq = g & ~g_q`, registered, so it fires only on the 0->1 edge of `g`.
  - Holding the condition produces no repeats.
  - Setting enable, or switching mode, while the condition is already true fires one pulse.
  - Clearing enable only drops `g`; no pulse.

## Timing
- **Reset values:** `keyinput` = 16'h03FF, `keypad_irq` = 0, `g_q` = 0, prescaler = 0, all `c` = 0, sync flops = 1.
- **Reset mid-count:** reset clears any partial agreement count; a held key must re-qualify from scratch.
- **Press latency** (raw edge to `keyinput` bit change): 2 sync cycles + up to SAMPLE_DIV to the next tick + (STABLE_SAMPLES-1)·SAMPLE_DIV + 1 register cycle.
- **IRQ latency:** `keypad_irq` rises 1 cycle after the `keyinput` change that completes the condition.
- **KEYCNT changes:** a `keycnt` change is reflected in `keypad_irq` on the next cycle.
- **Glitch rejection:** a raw glitch shorter than STABLE_SAMPLES consecutive samples never changes `keyinput`.
- **Simultaneous change and tick:** with STABLE_SAMPLES=1, every tick with a differing sample updates `s` immediately.
- **Multiple keys:** keys changing on the same tick update together. An AND condition completed by two keys on the same tick yields exactly one pulse.

## Structure
- Sub-module `key_debounce` (one bit): sync-free stable/counter logic, parameter STABLE_SAMPLES; instantiated 10 times. The synchronizer and prescaler stay in the parent.
- Added to `gba_mmio_defines.vh`:
  - KEYINPUT/KEYCNT register indices.
  - GBA key bit positions.
  - SNES bit positions.
  - KEYCNT field positions (IRQ_EN=14, COND=15).
- **Integration:** `gba_top` drives `interrupt_controller.keypad` from `keypad_irq`, replacing the 1'b0 tie-off. `mem_top` takes `keyinput` in place of the raw `buttons`.

## Test plan
SAMPLE_DIV=4, STABLE_SAMPLES=3 unless stated.
- **Reset:** hold reset with `buttons_raw`=16'h0000 -> `keyinput`=16'h03FF and `keypad_irq`=0 during reset. After release, `keyinput` reaches 16'h0000 within 2+4+8+1 cycles.
- **Remap:** drive SNES A low only (16'hFEFF) -> `keyinput`=16'h03FE. Drive SNES L low only (16'hFBFF) -> `keyinput`=16'h01FF.
- **Glitch:** pulse SNES Start low for 6 cycles (at most 2 samples) -> `keyinput` stays 16'h03FF.
- **OR IRQ:**
  - `keycnt`=16'h4003; press B -> exactly one `keypad_irq` pulse.
  - Keep B held and press A -> no further pulse.
  - Release both, press A -> one pulse.
- **AND IRQ:**
  - `keycnt`=16'hC00C; press Start only -> no pulse.
  - Add Select -> one pulse.
  - `keycnt`=16'hC000 with all keys pressed -> never a pulse.
- **Enable while held:** Right held with `keycnt`=16'h0010 -> no pulse. Write 16'h4010 -> one pulse the next cycle. Write 16'h0010, then 16'h4010 again -> one more pulse.
